// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
//   - scanner FSM state encoding
//   - 16-entry keymap, indexed by {row, col}
//   - direction key codes, also used by game_control's decoder
//   - helpers that classify an active-low row pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam logic [3:0] KEY_UP    = 4'h2;
  localparam logic [3:0] KEY_LEFT  = 4'h4;
  localparam logic [3:0] KEY_RIGHT = 4'h6;
  localparam logic [3:0] KEY_DOWN  = 4'h8;

  // Entry {row, col}: row 0 is the top row, col 0 the leftmost column.
  // '*' encodes as 4'hE and '#' as 4'hF.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // True when exactly one active-low row line is asserted.
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Index of the asserted row; only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational keymap lookup.
// Ports:
//   row_idx_i  in   2  row of the pressed key
//   col_idx_i  in   2  column of the pressed key
//   code_o     out  4  hex code of that key
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [1:0] col_idx_i,
  output logic [3:0] code_o
);

  assign code_o = KEYMAP[{row_idx_i, col_idx_i}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronised rows, debounces a single-key press and emits its hex code
// with a one-cycle valid pulse. A held key never repeats; the scanner only
// resumes after the rows have been released for DEB_CYCLES clocks.
// Ports:
//   clk_50MHz_i     in   1  system clock
//   rst_async_la_i  in   1  asynchronous active-low reset
//   row_i           in   4  keypad rows, active-low, asynchronous
//   col_o           out  4  keypad columns, one driven low at a time
//   key_code_o      out  4  last accepted key, held until the next one
//   key_valid_o     out  1  one-cycle pulse when key_code_o updates
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);

  // Reset synchroniser: assertion reaches the logic at once, release is
  // delayed two clocks so no flop leaves reset near an edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= rst_sync_d;
  end

  // Row synchroniser. Idle rows are high, so it resets to all-ones.
  logic [3:0] row_meta_q, row_meta_d;
  logic [3:0] rows_s_q,   rows_s_d;

  assign row_meta_d = row_i;
  assign rows_s_d   = row_meta_q;

  always_ff @(posedge clk_50MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      rows_s_q   <= 4'hF;
    end else begin
      row_meta_q <= row_meta_d;
      rows_s_q   <= rows_s_d;
    end
  end

  // Scanner state. col_q is only advanced from SCAN or when leaving
  // DEBOUNCE/HOLD, so it doubles as the latched column of the key.
  state_e           state_q,    state_d;
  logic [1:0]       col_q,      col_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [1:0]       row_idx_q,  row_idx_d;
  logic [3:0]       pat_q,      pat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       decoded_code;

  keypad_decode u_decode (
    .row_idx_i (row_idx_q),
    .col_idx_i (col_q),
    .code_o    (decoded_code)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          // Ambiguous patterns (no key, or several rows in one column) are
          // skipped rather than guessed at.
          if (single_low(rows_s_q)) begin
            state_d   = DEBOUNCE;
            row_idx_d = low_index(rows_s_q);
            pat_d     = rows_s_q;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rows_s_q != pat_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESS: begin
        key_code_d  = decoded_code;
        key_valid_d = 1'b1;
        state_d     = HOLD;
        cnt_d       = '0;
      end

      HOLD: begin
        // Any low row, including bounce, restarts the release timer.
        if (rows_s_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      row_idx_q   <= 2'd0;
      pat_q       <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_o       = ~(4'b0001 << col_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEB_CYCLES=8.
// A behavioural keypad pulls a row low whenever a pressed key sits in the
// column currently driven low.
module tb_keypad_scanner;

  logic       clk_50MHz = 1'b0;
  logic       rst_la;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  int         pulse_cnt  = 0;
  int         double_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] code_log [64];

  keypad_scanner #(
    .SCAN_DIV   (4),
    .DEB_CYCLES (8),
    .CNT_W      (20)
  ) dut (
    .clk_50MHz_i    (clk_50MHz),
    .rst_async_la_i (rst_la),
    .row_i          (row_i),
    .col_o          (col_o),
    .key_code_o     (key_code_o),
    .key_valid_o    (key_valid_o)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  // Pulse log, sampled on the falling edge.
  always @(negedge clk_50MHz) begin
    if (key_valid_o) begin
      code_log[pulse_cnt[5:0]] = key_code_o;
      pulse_cnt = pulse_cnt + 1;
      if (prev_valid) double_cnt = double_cnt + 1;
    end
    prev_valid = key_valid_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] one = 16'h0001;
    return one << (r*4 + c);
  endfunction

  // Advance n falling edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_50MHz);
    #1;
  endtask

  // Bounded wait for a given column pattern.
  task automatic wait_col(input logic [3:0] want, input string name);
    for (int i = 0; i < 64 && col_o !== want; i++) tick(1);
    total++;
    if (col_o !== want) begin
      bad++;
      $display("FAIL %s: col_o=%b never reached %b", name, col_o, want);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys   = 16'h0;
    rst_la = 1'b0;
    tick(3);
    total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", col_o); end
    total++; if (key_code_o !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code_o); end
    total++; if (key_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid_o); end
    rst_la = 1'b1;
    tick(2);  // internal release lags by two clocks
    total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL release_col: got %b want 1110", col_o); end
    for (int n = 1; n <= 16; n++) begin
      tick(1);
      exp_col = 4'b1111 ^ (4'b0001 << ((n / 4) % 4));
      total++;
      if (col_o !== exp_col) begin
        bad++;
        $display("FAIL idle_scan[%0d]: got %b want %b", n, col_o, exp_col);
      end
    end
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
    total++; if (key_code_o !== 4'h0) begin bad++; $display("FAIL idle_code: got %h want 0", key_code_o); end
  endtask

  task automatic test_single_key();
    int base = pulse_cnt;
    keys = kbit(0, 1);  // '2'
    tick(40);
    total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL key2_pulses: got %0d want 1", pulse_cnt - base); end
    total++; if (code_log[base[5:0]] !== 4'h2) begin bad++; $display("FAIL key2_code: got %h want 2", code_log[base[5:0]]); end
    total++; if (col_o !== 4'b1101) begin bad++; $display("FAIL key2_hold_col: got %b want 1101", col_o); end
    keys = 16'h0;
    tick(9);  // 2 sync clocks + 8 stable release clocks, last one still in HOLD
    total++; if (col_o !== 4'b1101) begin bad++; $display("FAIL key2_release_col: got %b want 1101", col_o); end
    tick(1);
    total++; if (col_o !== 4'b1011) begin bad++; $display("FAIL key2_resume_col: got %b want 1011", col_o); end
    total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL key2_no_repeat: got %0d want 1", pulse_cnt - base); end
    tick(10);
  endtask

  task automatic test_bounce();
    int base = pulse_cnt;
    for (int ph = 0; ph < 10; ph++) begin
      keys = (ph % 2 == 0) ? kbit(2, 1) : 16'h0;  // '8'
      tick(3);
    end
    total++; if (pulse_cnt - base !== 0) begin bad++; $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - base); end
    keys = kbit(2, 1);
    tick(8);
    total++; if (pulse_cnt - base !== 0) begin bad++; $display("FAIL bounce_early: got %0d want 0", pulse_cnt - base); end
    tick(40);
    total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL bounce_stable_pulses: got %0d want 1", pulse_cnt - base); end
    total++; if (key_code_o !== 4'h8) begin bad++; $display("FAIL bounce_code: got %h want 8", key_code_o); end
    keys = 16'h0;
    tick(20);
  endtask

  task automatic test_back_to_back();
    int base = pulse_cnt;
    keys = kbit(1, 2);  // '6'
    tick(40);
    keys = 16'h0;
    tick(20);
    total++; if (key_code_o !== 4'h6) begin bad++; $display("FAIL b2b_hold_code: got %h want 6", key_code_o); end
    keys = kbit(1, 0);  // '4'
    tick(40);
    total++; if (pulse_cnt - base !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - base); end
    total++; if (code_log[base[5:0]] !== 4'h6) begin bad++; $display("FAIL b2b_first: got %h want 6", code_log[base[5:0]]); end
    total++; if (code_log[6'(base + 1)] !== 4'h4) begin bad++; $display("FAIL b2b_second: got %h want 4", code_log[6'(base + 1)]); end
    keys = 16'h0;
    tick(20);
  endtask

  task automatic test_multi_key();
    int base = pulse_cnt;
    logic [3:0] col_before;
    keys = kbit(0, 0) | kbit(1, 0);  // '1' and '4', same column
    tick(40);
    total++; if (pulse_cnt - base !== 0) begin bad++; $display("FAIL same_col_pulses: got %0d want 0", pulse_cnt - base); end
    col_before = col_o;
    tick(4);
    total++; if (col_o === col_before) begin bad++; $display("FAIL same_col_scanning: col_o stuck at %b", col_o); end
    keys = 16'h0;
    tick(20);
    // Press '1' and '3' as column 3 starts so column 0 is scanned first.
    wait_col(4'b1011, "multi_wait_c2");
    wait_col(4'b0111, "multi_wait_c3");
    base = pulse_cnt;
    keys = kbit(0, 0) | kbit(0, 2);
    tick(40);
    total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL two_col_pulses: got %0d want 1", pulse_cnt - base); end
    total++; if (key_code_o !== 4'h1) begin bad++; $display("FAIL two_col_code: got %h want 1", key_code_o); end
    keys = 16'h0;
    tick(20);
  endtask

  task automatic test_reset_mid_debounce();
    int base;
    wait_col(4'b1110, "rst_wait_c0");
    wait_col(4'b1101, "rst_wait_c1");
    base = pulse_cnt;
    keys = kbit(3, 2);  // '#'
    // Column 2 opens 4 clocks later; DEBOUNCE is entered 4 clocks after that
    // and would reach PRESS 8 clocks later, so 10 clocks is mid-debounce.
    tick(10);
    total++; if (col_o !== 4'b1011) begin bad++; $display("FAIL deb_frozen_col: got %b want 1011", col_o); end
    rst_la = 1'b0;
    #1;
    total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL deb_reset_col: got %b want 1110", col_o); end
    total++; if (key_code_o !== 4'h0) begin bad++; $display("FAIL deb_reset_code: got %h want 0", key_code_o); end
    keys = 16'h0;
    tick(3);
    rst_la = 1'b1;
    tick(10);
    total++; if (pulse_cnt - base !== 0) begin bad++; $display("FAIL deb_reset_pulses: got %0d want 0", pulse_cnt - base); end
    keys = kbit(3, 2);
    tick(40);
    total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL hash_pulses: got %0d want 1", pulse_cnt - base); end
    total++; if (key_code_o !== 4'hF) begin bad++; $display("FAIL hash_code: got %h want f", key_code_o); end
    keys = 16'h0;
    tick(20);
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_back_to_back();
    test_multi_key();
    test_reset_mid_debounce();
    total++;
    if (double_cnt !== 0) begin
      bad++;
      $display("FAIL valid_width: %0d back-to-back valid cycles, want 0", double_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
